// File: rtl/cell_bist.sv
// cell_bist: built-in self test sequencer for a small combinational or
// pipelined cell. Walks an exhaustive N-bit pattern into the cell,
// compacts the cell responses in a 16-bit MISR and compares the final
// signature against a golden value.
//
// Ports
//   C      in   clock, rising edge
//   R      in   synchronous active-low reset
//   start  in   launch a run (only honoured in IDLE)
//   resp   in   [M-1:0] cell outputs, arrive LAT cycles after their pattern
//   gold   in   [SIGW-1:0] expected signature, sampled in DONE
//   pat    out  [N-1:0] pattern driven to the cell
//   busy   out  high while patterns are applied or responses drain
//   done   out  one-cycle pulse after busy falls
//   pass   out  result of the last completed run, held until next start
//   sig    out  [SIGW-1:0] running MISR signature
//
// State table
//   IDLE  | waiting for start, results held
//   RUN   | applying patterns 0..2^N-1, one per cycle
//   DRAIN | pattern forced to 0, collecting the last LAT responses
//   DONE  | signature final, compare against gold, pulse done

module cell_bist #(
  parameter int N    = 4,
  parameter int M    = 8,
  parameter int SIGW = 16,
  parameter int LAT  = 1
) (
  input  logic            C,
  input  logic            R,
  input  logic            start,
  input  logic [M-1:0]    resp,
  input  logic [SIGW-1:0] gold,
  output logic [N-1:0]    pat,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [SIGW-1:0] sig
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [N:0] CNT_LAST = {1'b0, {N{1'b1}}};
  localparam int         LAT_M1   = (LAT > 0) ? LAT - 1 : 0;
  localparam logic [1:0] DRN_LAST = 2'(LAT_M1);

  state_t          state_q, state_d;
  logic [N:0]      cnt_q, cnt_d;
  logic [1:0]      drn_q, drn_d;
  logic [N-1:0]    pat_q, pat_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [SIGW-1:0] sig_q, sig_d;

  logic [SIGW-1:0] misr_nxt;
  logic            run_upd;

  // During RUN the response for pattern k shows up in cycle k+LAT, so the
  // first LAT RUN cycles carry no valid response and must not be compacted.
  if (LAT == 0) begin : g_nolat
    assign run_upd = 1'b1;
  end else begin : g_lat
    localparam logic [N:0] LAT_C = (N+1)'(LAT);
    assign run_upd = (cnt_q >= LAT_C);
  end

  // MISR: shift up with feedback x^16 taps at 15,13,12,10, response bits
  // folded into the low M stages.
  always_comb begin
    misr_nxt = {sig_q[SIGW-2:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]};
    for (int i = 0; i < M; i++) begin
      misr_nxt[i] = misr_nxt[i] ^ resp[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    pat_d   = pat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    sig_d   = sig_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          pat_d   = '0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          sig_d   = '0;
        end
      end

      RUN: begin
        if (run_upd) begin
          sig_d = misr_nxt;
        end
        if (cnt_q == CNT_LAST) begin
          pat_d = '0;
          drn_d = '0;
          if (LAT > 0) begin
            state_d = DRAIN;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          pat_d = cnt_q[N-1:0] + 1'b1;
        end
      end

      DRAIN: begin
        sig_d = misr_nxt;
        pat_d = '0;
        if (drn_q == DRN_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end

      DONE: begin
        pass_d  = (sig_q == gold);
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (!R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drn_q   <= '0;
      pat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      pat_q   <= pat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
    end
  end

  assign pat  = pat_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign sig  = sig_q;

endmodule

// File: doc/cell_bist.md
CELL_BIST -- requirements
Module: cell_bist

Interface
REQ-001 SHALL have parameter N, default 4, pattern width driving cell-under-test inputs (1..8).
REQ-002 SHALL have parameter M, default 8, response width, one bit per cell-under-test output (1..SIGW).
REQ-003 SHALL have parameter SIGW, default 16, signature width (fixed 16).
REQ-004 SHALL have parameter LAT, default 1, cycles from pattern to matching response (0..3).
REQ-005 SHALL have port C  input  1  clock, all state updates on rising edge.
REQ-006 SHALL have port R  input  1  reset: one clock; reset is synchronous and active-low.
REQ-007 SHALL have port start  input  1  begin a test run, sampled in IDLE only.
REQ-008 SHALL have port resp  input  M  cell-under-test outputs.
REQ-009 SHALL have port gold  input  SIGW  expected signature, sampled in DONE.
REQ-010 SHALL have port pat  output  N  registered pattern to cell-under-test inputs.
REQ-011 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-013 SHALL have port pass  output  1  sticky result of last run.
REQ-014 SHALL have port sig  output  SIGW  current MISR signature.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; all outputs registered.
REQ-016 IDLE: start=1 -> RUN next cycle; sig cleared to 0, pattern counter to 0, pass cleared to 0.
REQ-017 RUN: pat = counter, counts 0..2^N-1, one value per cycle, unsigned, no skips.
REQ-018 RUN: after pat = 2^N-1 -> DRAIN if LAT>0, else DONE.
REQ-019 DRAIN: pat = 0; remains exactly LAT cycles, then DONE.
REQ-020 MISR SHALL update exactly 2^N times, on the edges ending cycles k+LAT, k = 0..2^N-1, where k counts RUN cycles from 0; no update in any other cycle.
REQ-021 MISR update: sig[0] <= sig[15]^sig[13]^sig[12]^sig[10]^resp[0]; sig[i] <= sig[i-1]^resp[i] for 1<=i<M; sig[i] <= sig[i-1] for i>=M.
REQ-022 DONE: lasts one cycle; done=1; pass <= (sig == gold); then -> IDLE.
REQ-023 pass and sig SHALL hold their values in IDLE until the next accepted start.
REQ-024 start while busy or in DONE SHALL be ignored, with no queuing.
REQ-025 Total busy duration SHALL be 2^N+LAT cycles; done SHALL assert in the cycle after busy falls.
REQ-026 Counter SHALL be N+1 bits wide; no wrap-around of pat SHALL occur within a run.

Reset
REQ-027 R=0 at a rising edge SHALL force IDLE, pat=0, sig=0, busy=0, done=0, pass=0.
REQ-028 Reset SHALL take priority over start and over any in-progress run; after reset a new start is required.
REQ-029 R SHALL have no asynchronous effect; outputs change only on C edges.

Verification
REQ-030 Reset check: drive R=0 for 2 cycles with start=1 and random resp -> all outputs 0 and state IDLE; release R -> no run begins until a fresh start while IDLE.
REQ-031 N=2, M=1, LAT=0, resp=0, gold=0x0000, start pulse -> pat 0,1,2,3 on consecutive cycles; busy high 4 cycles; done pulse next cycle; sig=0x0000; pass=1.
REQ-032 N=2, M=1, LAT=0, resp[0]=1 only while pat=0, gold=0x0008 -> sig 0x0001,0x0002,0x0004,0x0008; pass=1; repeat with gold=0x0000 -> pass=0.
REQ-033 N=2, LAT=2, resp delayed 2 cycles through DFF cells -> busy 6 cycles; pat=0 during 2 DRAIN cycles; sig equals LAT=0 run with undelayed resp.
REQ-034 Start pulses at cycles 2 and 5 of a run -> ignored; exactly one done pulse; the following IDLE start launches a new run with sig reset to 0.
REQ-035 R=0 during RUN at pat=2 -> next cycle IDLE, busy=0, sig=0, no done pulse; a subsequent start completes a normal run.
